// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams bytes into instruction memory.
// Stream: count lo, count hi (N words), then N*4 data bytes, little-endian per word.
// The core is held in synchronous reset until a load completes successfully.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum
// byte that makes the 8-bit sum of all data bytes plus itself equal to zero.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_start,
  input  logic              i_byteValid,
  input  logic [7:0]        i_byte,
  output logic              o_byteReady,
  output logic              o_wrEn,
  output logic [ADDR_W-1:0] o_wrAddr,
  output logic [31:0]       o_wrData,
  output logic              o_coreSrst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK  = 3'd4;
`endif
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam logic [15:0] MAX_WORDS = 16'(DEPTH);

  logic [2:0]        state_q, state_d;
  // Set for the single cycle the final write is on the bus; DONE follows it.
  logic              fin_q, fin_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic              busy_d;
  logic              accept;
  logic [15:0]       n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        chk;
`endif

  assign accept = i_byteValid & o_byteReady;

  // Next-state logic: handshake, count decode, word assembly and write issue.
  always_comb begin
    state_d   = state_q;
    fin_d     = fin_q;
    count_d   = count_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = o_wrAddr;
    wr_data_d = o_wrData;
    n_words   = {i_byte, count_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk       = sum_q + i_byte;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d   = ST_CNT_LO;
          fin_d     = 1'b0;
          wcnt_d    = '0;
          bcnt_d    = '0;
          word_d    = '0;
          wr_addr_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          count_d[7:0] = i_byte;
          state_d      = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          count_d[15:8] = i_byte;
          if (n_words == 16'd0 || n_words > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = ST_DONE;
        end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + i_byte;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0:    word_d[7:0]   = i_byte;
            2'd1:    word_d[15:8]  = i_byte;
            2'd2:    word_d[23:16] = i_byte;
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = wcnt_q[ADDR_W-1:0];
              wr_data_d = {i_byte, word_q};
              wcnt_d    = wcnt_q + 16'd1;
              if (wcnt_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = ST_CHECK;
`else
                fin_d   = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          state_d = (chk == 8'd0) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
  end

  // State and registered outputs; all outputs decode from next state.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= ST_IDLE;
      fin_q       <= 1'b0;
      count_q     <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
      o_byteReady <= 1'b0;
      o_wrEn      <= 1'b0;
      o_wrAddr    <= '0;
      o_wrData    <= '0;
      o_coreSrst  <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_q       <= fin_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
      o_byteReady <= busy_d & ~fin_d;
      o_wrEn      <= wr_en_d;
      o_wrAddr    <= wr_addr_d;
      o_wrData    <= wr_data_d;
      o_coreSrst  <= (state_d != ST_DONE);
      o_busy      <= busy_d;
      o_done      <= (state_d == ST_DONE);
      o_error     <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random images, gaps, bad counts, async abort, restart.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_arstn, i_start, i_byteValid;
  logic [7:0]    i_byte;
  logic          o_byteReady, o_wrEn, o_coreSrst, o_busy, o_done, o_error;
  logic [AW-1:0] o_wrAddr;
  logic [31:0]   o_wrData;

  int checks = 0;
  int errors = 0;

  // Behavioural instruction memory written by the loader's write port.
  logic [31:0] imem [DEPTH];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_arstn(i_arstn), .i_start(i_start), .i_byteValid(i_byteValid),
    .i_byte(i_byte), .o_byteReady(o_byteReady), .o_wrEn(o_wrEn), .o_wrAddr(o_wrAddr),
    .o_wrData(o_wrData), .o_coreSrst(o_coreSrst), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_wrEn) imem[o_wrAddr] <= o_wrData;

  // Reference stream: count, little-endian words, optional zero-sum checksum.
  function automatic void build_stream(input logic [15:0] n, input logic [31:0] words[$],
                                       input bit cs_good, output logic [7:0] s[$]);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    s = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) begin
        b = words[w][8*k +: 8];
        s.push_back(b);
        sum = sum + b;
      end
    end
    if (CS && words.size() > 0) s.push_back(8'(8'd0 - sum) + (cs_good ? 8'd0 : 8'd1));
  endfunction

  task automatic pulse_start(input string tag);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    checks++;
    if (o_byteReady !== 1'b1 || o_busy !== 1'b1 || o_coreSrst !== 1'b1 || o_done !== 1'b0 ||
        o_error !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: rdy=%b busy=%b srst=%b done=%b err=%b, required 1 1 1 0 0",
               tag, o_byteReady, o_busy, o_coreSrst, o_done, o_error);
    end
  endtask

  // mode 0: valid every cycle, 1: toggling, 2: random gaps.
  task automatic send_bytes(input logic [7:0] s[$], input logic [31:0] words[$],
                            input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    int pos = 0;
    int d;
    logic v, rdy;
    while (idx < s.size()) begin
      if (cyc >= 4000) begin
        errors++;
        $display("FAIL %s_timeout: accepted %0d bytes, required %0d", tag, idx, s.size());
        break;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      i_byteValid = v;
      i_byte = v ? s[idx] : 8'($urandom);
      rdy = o_byteReady;
      @(posedge i_clk); #1;
      cyc++;
      d = -1;
      if (v && rdy) begin
        d = pos - 2;
        pos++;
        idx++;
      end
      checks++;
      if (d >= 0 && d < 4 * words.size() && d % 4 == 3) begin
        if (o_wrEn !== 1'b1 || o_wrAddr !== AW'(d / 4) || o_wrData !== words[d / 4]) begin
          errors++;
          $display("FAIL %s_write: en=%b addr=%0d data=%h, required 1 %0d %h", tag, o_wrEn,
                   o_wrAddr, o_wrData, d / 4, words[d / 4]);
        end
      end else if (o_wrEn !== 1'b0) begin
        errors++;
        $display("FAIL %s_nowrite: en=%b addr=%0d, required en=0 (cycle %0d)", tag, o_wrEn,
                 o_wrAddr, cyc);
      end
    end
    i_byteValid = 1'b0;
  endtask

  // Called right after the last stream byte is accepted.
  task automatic finish_load(input bit ok, input logic [31:0] words[$], input string tag);
    if (!CS && ok) begin
      checks++;
      if (o_done !== 1'b0 || o_coreSrst !== 1'b1) begin
        errors++;
        $display("FAIL %s_wrcycle: done=%b srst=%b, required 0 1", tag, o_done, o_coreSrst);
      end
      @(posedge i_clk); #1;
    end
    checks++;
    if (o_done !== ok || o_error !== !ok || o_coreSrst !== !ok || o_busy !== 1'b0 ||
        o_byteReady !== 1'b0 || o_wrEn !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: done=%b err=%b srst=%b busy=%b rdy=%b en=%b, required %b %b %b 0 0 0",
               tag, o_done, o_error, o_coreSrst, o_busy, o_byteReady, o_wrEn, ok, !ok, !ok);
    end
    foreach (words[i]) begin
      checks++;
      if (imem[i] !== words[i]) begin
        errors++;
        $display("FAIL %s_imem[%0d]: got %h, required %h", tag, i, imem[i], words[i]);
      end
    end
  endtask

  task automatic test_reset();
    i_arstn = 1'b1; i_start = 1'b0; i_byteValid = 1'b0; i_byte = 8'h00;
    #2 i_arstn = 1'b0;
    #10;
    checks++;
    if (o_byteReady !== 1'b0 || o_wrEn !== 1'b0 || o_wrAddr !== '0 || o_wrData !== '0 ||
        o_coreSrst !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b en=%b addr=%0d data=%h srst=%b busy=%b done=%b err=%b",
               o_byteReady, o_wrEn, o_wrAddr, o_wrData, o_coreSrst, o_busy, o_done, o_error);
    end
    @(posedge i_clk); #1;
    i_arstn = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_byteReady !== 1'b0 || o_busy !== 1'b0 || o_coreSrst !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b busy=%b srst=%b, required 0 0 1",
               o_byteReady, o_busy, o_coreSrst);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$] = '{32'h00000513, 32'h00100093};
    logic [7:0] s[$];
    build_stream(16'd2, w, 1'b1, s);
    pulse_start("basic");
    send_bytes(s, w, 0, "basic");
    finish_load(1'b1, w, "basic");
  endtask

  task automatic test_restart();
    logic [31:0] w[$] = '{32'hdeadbeef, 32'h12345678, 32'h0badf00d};
    logic [7:0] s[$];
    build_stream(16'd3, w, 1'b1, s);
    pulse_start("restart");
    send_bytes(s, w, 0, "restart");
    finish_load(1'b1, w, "restart");
  endtask

  task automatic test_bad_count();
    logic [31:0] none[$] = {};
    logic [7:0] s[$];
    build_stream(16'h0041, none, 1'b1, s);
    pulse_start("cnt41");
    send_bytes(s, none, 0, "cnt41");
    finish_load(1'b0, none, "cnt41");
    build_stream(16'h0000, none, 1'b1, s);
    pulse_start("cnt0");
    send_bytes(s, none, 0, "cnt0");
    finish_load(1'b0, none, "cnt0");
  endtask

  task automatic test_checksum_bad();
    logic [31:0] w[$] = '{32'h00000513, 32'h00100093};
    logic [7:0] s[$];
    build_stream(16'd2, w, 1'b0, s);
    pulse_start("cksum");
    send_bytes(s, w, 0, "cksum");
    finish_load(1'b0, w, "cksum");
  endtask

  task automatic test_gaps();
    logic [31:0] w[$] = '{32'h00000513, 32'h00100093};
    logic [7:0] s[$];
    build_stream(16'd2, w, 1'b1, s);
    pulse_start("gaps");
    send_bytes(s, w, 1, "gaps");
    finish_load(1'b1, w, "gaps");
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [7:0] s[$];
    int n;
    bit good;
    for (int it = 0; it < 6; it++) begin
      n = (it == 5) ? DEPTH : $urandom_range(1, 7);
      good = CS ? 1'($urandom_range(0, 1)) : 1'b1;
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      build_stream(16'(n), w, good, s);
      pulse_start("random");
      send_bytes(s, w, $urandom_range(0, 2), "random");
      finish_load(good, w, "random");
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w[$] = '{32'hcafe0001, 32'hcafe0002};
    logic [31:0] w2[$] = '{32'h11223344, 32'h55667788};
    logic [7:0] s[$];
    logic [7:0] part[$];
    build_stream(16'd2, w, 1'b1, s);
    part = s[0:7];
    pulse_start("abort");
    send_bytes(part, w, 0, "abort");
    #2 i_arstn = 1'b0;
    #1;
    checks++;
    if (o_byteReady !== 1'b0 || o_wrEn !== 1'b0 || o_wrAddr !== '0 || o_wrData !== '0 ||
        o_coreSrst !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL abort_values: rdy=%b en=%b addr=%0d data=%h srst=%b busy=%b done=%b err=%b",
               o_byteReady, o_wrEn, o_wrAddr, o_wrData, o_coreSrst, o_busy, o_done, o_error);
    end
    checks++;
    if (imem[0] !== w[0]) begin
      errors++;
      $display("FAIL abort_kept_word: got %h, required %h", imem[0], w[0]);
    end
    @(posedge i_clk); #1;
    i_arstn = 1'b1;
    @(posedge i_clk); #1;
    build_stream(16'd2, w2, 1'b1, s);
    pulse_start("reload");
    send_bytes(s, w2, 2, "reload");
    finish_load(1'b1, w2, "reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_bad_count();
    if (CS) test_checksum_bad();
    test_gaps();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
